// File: rtl/s2c_call_arbiter.sv
// s2c_call_arbiter: round-robin arbiter serialising setup/call/check_end transactions onto the single s2c channel.
// Optional response timeout is compiled in when S2C_CALL_ARBITER_TIMEOUT_EN is defined.
module s2c_call_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_kind,
    input  logic [32*NUM_REQ-1:0]     req_id,
    input  logic [32*NUM_REQ-1:0]     req_fn,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [31:0]               rsp_ret,
    output logic [32*DATA_SIZE-1:0]   rsp_data,
    output logic                      ch_req_valid,
    input  logic                      ch_req_ready,
    output logic [1:0]                ch_kind,
    output logic [31:0]               ch_id,
    output logic [31:0]               ch_fn,
    input  logic                      ch_rsp_valid,
    input  logic [31:0]               ch_ret,
    input  logic [32*DATA_SIZE-1:0]   ch_data
);

    localparam int unsigned GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DW       = 32 * DATA_SIZE;
    localparam logic [GW:0]   NREQ_W   = (GW+1)'(NUM_REQ);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);
    localparam logic [1:0]  KIND_CALL = 2'd1;
    localparam logic [1:0]  KIND_END  = 2'd2;
    localparam logic [1:0]  KIND_RSVD = 2'd3;
    localparam logic [31:0] RET_RSVD  = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    logic [1:0]          kind_q, kind_d;
    logic [31:0]         id_q, id_d;
    logic [31:0]         fn_q, fn_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                ch_req_valid_q, ch_req_valid_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_ret_q, rsp_ret_d;
    logic [DW-1:0]       rsp_data_q, rsp_data_d;
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RET_TMO  = 32'hFFFF_FFFF;
    logic [31:0]         cnt_q, cnt_d;
`endif

    logic [1:0]          kind_a [NUM_REQ];
    logic [31:0]         id_a   [NUM_REQ];
    logic [31:0]         fn_a   [NUM_REQ];
    logic                any_valid;
    logic [GW-1:0]       pick;
    logic [GW:0]         cand_w;
    logic [GW-1:0]       cand;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [NUM_REQ-1:0]  gnt_oh;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign kind_a[i] = req_kind[2*i +: 2];
        assign id_a[i]   = req_id[32*i +: 32];
        assign fn_a[i]   = req_fn[32*i +: 32];
    end

    // First valid requester at or after the pointer, wrapping past the last index.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand_w    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_w = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand_w >= NREQ_W) begin
                cand_w = cand_w - NREQ_W;
            end
            cand = cand_w[GW-1:0];
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
        gnt_oh        = '0;
        gnt_oh[gnt_q] = 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        gnt_d          = gnt_q;
        kind_d         = kind_q;
        id_d           = id_q;
        fn_d           = fn_q;
        req_ready_d    = '0;
        ch_req_valid_d = 1'b0;
        rsp_valid_d    = rsp_valid_q;
        rsp_ret_d      = rsp_ret_q;
        rsp_data_d     = rsp_data_q;
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    gnt_d       = pick;
                    req_ready_d = pick_oh;
                    kind_d      = kind_a[pick];
                    if (kind_a[pick] == KIND_END) begin
                        id_d = '0;
                        fn_d = 32'd2;
                    end else begin
                        id_d = id_a[pick];
                        fn_d = fn_a[pick];
                    end
                    if (kind_a[pick] == KIND_RSVD) begin
                        rsp_ret_d   = RET_RSVD;
                        rsp_data_d  = '0;
                        rsp_valid_d = pick_oh;
                        state_d     = ST_RETURN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // ch_req_valid rises one cycle into ISSUE, giving the 2-cycle request latency.
                if (ch_req_valid_q && ch_req_ready) begin
                    state_d = ST_WAIT;
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    ch_req_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (ch_rsp_valid) begin
                    rsp_ret_d   = ch_ret;
                    rsp_data_d  = (kind_q == KIND_CALL) ? ch_data : '0;
                    rsp_valid_d = gnt_oh;
                    state_d     = ST_RETURN;
                end
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    rsp_ret_d   = RET_TMO;
                    rsp_data_d  = '0;
                    rsp_valid_d = gnt_oh;
                    state_d     = ST_RETURN;
                end
`endif
            end
            ST_RETURN: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                    ptr_d       = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            gnt_q          <= '0;
            kind_q         <= '0;
            id_q           <= '0;
            fn_q           <= '0;
            req_ready_q    <= '0;
            ch_req_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_ret_q      <= '0;
            rsp_data_q     <= '0;
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gnt_q          <= gnt_d;
            kind_q         <= kind_d;
            id_q           <= id_d;
            fn_q           <= fn_d;
            req_ready_q    <= req_ready_d;
            ch_req_valid_q <= ch_req_valid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_ret_q      <= rsp_ret_d;
            rsp_data_q     <= rsp_data_d;
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_ret      = rsp_ret_q;
    assign rsp_data     = rsp_data_q;
    assign ch_req_valid = ch_req_valid_q;
    assign ch_kind      = kind_q;
    assign ch_id        = id_q;
    assign ch_fn        = fn_q;

endmodule

// File: tb/tb_s2c_call_arbiter.sv
// Testbench for s2c_call_arbiter: directed scenarios plus randomized traffic against a queue-level model.
// Timeout scenario follows S2C_CALL_ARBITER_TIMEOUT_EN.
module tb_s2c_call_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DS   = 8;
    localparam int unsigned DW   = 32 * DS;
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
    localparam int unsigned TMO  = 16;
`else
    localparam int unsigned TMO  = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_kind;
    logic [32*NREQ-1:0] req_id;
    logic [32*NREQ-1:0] req_fn;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [31:0]       rsp_ret;
    logic [DW-1:0]     rsp_data;
    logic              ch_req_valid;
    logic              ch_req_ready;
    logic [1:0]        ch_kind;
    logic [31:0]       ch_id;
    logic [31:0]       ch_fn;
    logic              ch_rsp_valid;
    logic [31:0]       ch_ret;
    logic [DW-1:0]     ch_data;

    always #5 clk = ~clk;

    s2c_call_arbiter #(
        .NUM_REQ       (NREQ),
        .DATA_SIZE     (DS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_id      (req_id),
        .req_fn      (req_fn),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_ret     (rsp_ret),
        .rsp_data    (rsp_data),
        .ch_req_valid(ch_req_valid),
        .ch_req_ready(ch_req_ready),
        .ch_kind     (ch_kind),
        .ch_id       (ch_id),
        .ch_fn       (ch_fn),
        .ch_rsp_valid(ch_rsp_valid),
        .ch_ret      (ch_ret),
        .ch_data     (ch_data)
    );

    int checks = 0;
    int errors = 0;

    // Model: pending requests per requester plus the round-robin pointer.
    int unsigned ptr_m;
    bit          pend [NREQ];
    logic [1:0]  pk   [NREQ];
    logic [31:0] pid  [NREQ];
    logic [31:0] pfn  [NREQ];

    int unsigned   g_exp;
    logic [1:0]    k_exp;
    logic [31:0]   id_exp, fn_exp, ret_exp;
    logic [DW-1:0] data_exp;
    int            lat;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk(tag, DW'(obs), DW'(exp));
    endtask

    function automatic logic [31:0] oh(input int unsigned i);
        logic [31:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        r = '0;
        for (int w = 0; w < DS; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    function automatic int unsigned model_pick();
        for (int unsigned k = 0; k < NREQ; k++)
            if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        return 0;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = pend[i];
            req_kind[2*i +: 2]   = pk[i];
            req_id[32*i +: 32]   = pid[i];
            req_fn[32*i +: 32]   = pfn[i];
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [1:0] k, input logic [31:0] id, input logic [31:0] fn);
        pend[i] = 1'b1;
        pk[i]   = k;
        pid[i]  = id;
        pfn[i]  = fn;
    endtask

    task automatic set_rand_req(input int unsigned i);
        set_req(i, 2'($urandom_range(0, 3)), $urandom(), $urandom());
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk32({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk32({tag, "_rsp_ret"}, rsp_ret, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk32({tag, "_ch_req_valid"}, 32'(ch_req_valid), 32'd0);
        chk32({tag, "_ch_kind"}, 32'(ch_kind), 32'd0);
        chk32({tag, "_ch_id"}, ch_id, 32'd0);
        chk32({tag, "_ch_fn"}, ch_fn, 32'd0);
    endtask

    task automatic grant_phase(input bit reload);
        int n;
        g_exp    = model_pick();
        k_exp    = pk[g_exp];
        id_exp   = (k_exp == 2'd2) ? 32'd0 : pid[g_exp];
        fn_exp   = (k_exp == 2'd2) ? 32'd2 : pfn[g_exp];
        ret_exp  = 32'hFFFF_FFFE;
        data_exp = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        chk32("grant", 32'(req_ready), oh(g_exp));
        lat = n;
        if (reload) set_rand_req(g_exp);
        else pend[g_exp] = 1'b0;
        drive_reqs();
    endtask

    task automatic issue_phase(input int bp);
        int n;
        chk32("ch_valid_at_grant", 32'(ch_req_valid), 32'd0);
        @(negedge clk);
        n = 1;
        chk32("ready_one_cycle", 32'(req_ready), 32'd0);
        while (ch_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat += n;
        chk32("ch_req_valid", 32'(ch_req_valid), 32'd1);
        chk32("ch_kind", 32'(ch_kind), 32'(k_exp));
        chk32("ch_id", ch_id, id_exp);
        chk32("ch_fn", ch_fn, fn_exp);
        for (int c = 0; c < bp; c++) begin
            ch_rsp_valid = 1'($urandom_range(0, 1));
            ch_ret       = $urandom();
            ch_data      = rand_data();
            @(negedge clk);
            ch_rsp_valid = 1'b0;
            chk32("hold_ch_valid", 32'(ch_req_valid), 32'd1);
            chk32("hold_ch_id", ch_id, id_exp);
            chk32("hold_ch_fn", ch_fn, fn_exp);
            chk32("hold_no_rsp", 32'(rsp_valid), 32'd0);
            chk32("stall_no_grant", 32'(req_ready), 32'd0);
        end
        ch_req_ready = 1'b1;
        @(negedge clk);
        ch_req_ready = 1'b0;
        chk32("ch_valid_drop", 32'(ch_req_valid), 32'd0);
    endtask

    task automatic respond_phase(input int dly, input logic [31:0] ret, input logic [DW-1:0] data);
        for (int c = 0; c < dly; c++) begin
            chk32("wait_no_rsp", 32'(rsp_valid), 32'd0);
            chk32("single_issue", 32'(ch_req_valid), 32'd0);
            @(negedge clk);
        end
        ch_rsp_valid = 1'b1;
        ch_ret       = ret;
        ch_data      = data;
        @(negedge clk);
        ch_rsp_valid = 1'b0;
        ch_ret       = $urandom();
        ch_data      = rand_data();
        ret_exp      = ret;
        data_exp     = (k_exp == 2'd1) ? data : '0;
        chk32("rsp_latency", 32'(rsp_valid), oh(g_exp));
    endtask

    task automatic rsvd_phase();
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk32("rsvd_not_issued", 32'(ch_req_valid), 32'd0);
    endtask

    task automatic return_phase(input int rdly);
        chk32("rsp_valid", 32'(rsp_valid), oh(g_exp));
        chk32("rsp_ret", rsp_ret, ret_exp);
        chk("rsp_data", rsp_data, data_exp);
        for (int c = 0; c < rdly; c++) begin
            rsp_ready = NREQ'($urandom()) & ~NREQ'(oh(g_exp));
            @(negedge clk);
            chk32("hold_rsp_valid", 32'(rsp_valid), oh(g_exp));
            chk32("hold_rsp_ret", rsp_ret, ret_exp);
            chk("hold_rsp_data", rsp_data, data_exp);
            chk32("ret_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = NREQ'($urandom()) | NREQ'(oh(g_exp));
        @(negedge clk);
        rsp_ready = '0;
        chk32("rsp_done", 32'(rsp_valid), 32'd0);
        ptr_m = (g_exp + 1) % NREQ;
    endtask

    task automatic run_txn(input bit reload, input int bp, input int dly, input int rdly,
                           input logic [31:0] ret, input logic [DW-1:0] data);
        grant_phase(reload);
        if (k_exp == 2'd3) begin
            rsvd_phase();
        end else begin
            issue_phase(bp);
            respond_phase(dly, ret, data);
        end
        return_phase(rdly);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] seq_data;
        bit            seen;
        int            n;

        rst_n        = 1'b0;
        req_valid    = '0;
        req_kind     = '0;
        req_id       = '0;
        req_fn       = '0;
        rsp_ready    = '0;
        ch_req_ready = 1'b0;
        ch_rsp_valid = 1'b0;
        ch_ret       = '0;
        ch_data      = '0;
        ptr_m        = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pk[i] = '0; pid[i] = '0; pfn[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single call from requester 0, response 3 cycles after issue.
        for (int w = 0; w < DS; w++) seq_data[32*w +: 32] = 32'(w);
        set_req(0, 2'd1, 32'd5, 32'd7);
        drive_reqs();
        grant_phase(1'b0);
        issue_phase(0);
        chk32("req_to_ch_latency", 32'(lat), 32'd2);
        respond_phase(3, 32'd0, seq_data);
        return_phase(0);

        // Check-end from requester 2 is sanitised and returns no data.
        set_req(2, 2'd2, 32'h55, 32'd9);
        drive_reqs();
        run_txn(1'b0, 0, 1, 0, 32'd1, rand_data());

        // Bring the pointer back to 0.
        set_req(3, 2'd1, 32'h33, 32'h44);
        drive_reqs();
        run_txn(1'b0, 0, 0, 0, 32'hFFFF_FF00, rand_data());

        // Continuous contention: grants rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_rand_req(i);
        drive_reqs();
        for (int t = 0; t < 5; t++) run_txn(1'b1, 0, 1, 0, $urandom(), rand_data());

        // Backpressure on both channel request and response; others stay valid.
        set_req(1, 2'd1, 32'hABCD, 32'h1234);
        drive_reqs();
        run_txn(1'b0, 5, 2, 4, 32'h8000_0001, rand_data());

        // Randomized traffic with drops before grant.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && $urandom_range(0, 4) == 0) pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(0, 1) == 1) set_rand_req(i);
            end
            if (!(pend[0] | pend[1] | pend[2] | pend[3])) set_rand_req($urandom_range(0, NREQ - 1));
            drive_reqs();
            run_txn(1'b0, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom(), rand_data());
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // Unanswered channel request.
        set_req(1, 2'd1, 32'h77, 32'h88);
        drive_reqs();
        grant_phase(1'b0);
        issue_phase(0);
`ifdef S2C_CALL_ARBITER_TIMEOUT_EN
        n = 0;
        while (rsp_valid == '0 && n < int'(TMO) + 8) begin
            @(negedge clk);
            n++;
        end
        chk32("timeout_cycles", 32'(n), 32'(TMO));
        ret_exp  = 32'hFFFF_FFFF;
        data_exp = '0;
        return_phase(0);
        set_req(1, 2'd1, 32'h77, 32'h88);
        drive_reqs();
        grant_phase(1'b0);
        issue_phase(0);
`else
        seen = 1'b0;
        n    = 0;
        repeat (2000) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        chk32("no_timeout", 32'(seen), 32'd0);
`endif

        // Reset while waiting, then a stray response after release.
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_in_wait");
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        drive_reqs();
        @(negedge clk);
        ch_rsp_valid = 1'b1;
        ch_ret       = 32'd7;
        ch_data      = rand_data();
        @(negedge clk);
        ch_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk32("stray_no_rsp", 32'(rsp_valid), 32'd0);
            chk32("stray_no_issue", 32'(ch_req_valid), 32'd0);
        end
        set_req(2, 2'd1, 32'h99, 32'hAA);
        drive_reqs();
        run_txn(1'b0, 1, 2, 1, 32'd3, rand_data());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2c_call_arbiter.md
Name: s2c_call_arbiter

Overview:
- Shares the single server-to-client (s2c) function-call channel among NUM_REQ requesters.
- Each requester issues a setup, call or check-end transaction (id, fn). The arbiter grants round-robin, issues one transaction at a time on the channel, waits for the response, and returns ret/data to the originating requester.
- Sits between bench-side agents and the s2c bridge; it is the single point of ordering for all s2c traffic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_SIZE, 8, 32-bit data words returned per call transaction
- TIMEOUT_CYCLES, 1024, cycles to wait for a channel response (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_kind  in  2*NUM_REQ  per-requester kind: 0=setup, 1=call, 2=check_end, 3=reserved
- req_id  in  32*NUM_REQ  per-requester id
- req_fn  in  32*NUM_REQ  per-requester function number
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_ret  out  32  return code (signed)
- rsp_data  out  32*DATA_SIZE  returned data words
- ch_req_valid  out  1  channel request valid
- ch_req_ready  in  1  channel accepts request
- ch_kind  out  2  kind to channel
- ch_id  out  32  id to channel
- ch_fn  out  32  fn to channel
- ch_rsp_valid  in  1  channel response strobe (single cycle)
- ch_ret  in  32  channel return code
- ch_data  in  32*DATA_SIZE  channel data

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- FSM states:
  - IDLE: if any req_valid, grant the first valid index at or after the pointer (wrapping). Assert req_ready[g] for exactly one cycle, latch kind/id/fn, go to ISSUE.
  - ISSUE: drive ch_req_valid=1 with the latched fields. Hold them stable until ch_req_ready. On the handshake cycle go to WAIT.
  - WAIT: on ch_rsp_valid, latch ch_ret. Latch ch_data only for kind=1; otherwise rsp_data is forced to 0. Go to RETURN.
  - RETURN: rsp_valid[g]=1, with rsp_ret/rsp_data stable until rsp_ready[g]. On that handshake go to IDLE and set the pointer to g+1 mod NUM_REQ.
- Request sanitising:
  - kind=2 forces ch_id=0 and ch_fn=2 regardless of the inputs.
  - kind=3 is not issued. The arbiter accepts it, skips ISSUE/WAIT and returns ret=0xFFFFFFFE with data=0 (ISSUE/WAIT skipped, RETURN on the next cycle).
- Only one transaction is outstanding. Other requesters stall with req_ready=0.
- Minimum latency from req_valid to ch_req_valid is 2 cycles; from ch_rsp_valid to rsp_valid it is 1 cycle.
- A ch_rsp_valid seen outside WAIT is ignored.
- A requester dropping req_valid before grant is legal. req_valid is not re-sampled after grant.
- Simultaneous requests are granted strictly round-robin; no requester waits more than NUM_REQ-1 grants.
- Reset mid-transaction returns to IDLE immediately and discards the pending response. A later stray ch_rsp_valid is ignored.

Optional Feature:
- Macro: S2C_CALL_ARBITER_TIMEOUT_EN.
- When defined: a 32-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without ch_rsp_valid, the arbiter goes to RETURN with ret=0xFFFFFFFF and data=0. A ch_rsp_valid arriving in the same cycle as expiry takes priority (normal response).
- When undefined: WAIT waits indefinitely and the counter logic is absent.

Test Plan:
1. Single call: req0 kind=1 id=5 fn=7; channel returns ret=0 and data words 0..7 after 3 cycles -> ch_id=5, ch_fn=7 issued; rsp_valid[0] with ret=0 and data 0..7.
2. Check end: req2 kind=2 id=0x55 fn=9 -> channel sees id=0, fn=2; a ch_ret=1 response gives rsp_ret=1 and rsp_data=0.
3. Contention: all four requesters valid continuously with pointer at 0 -> grant order 0,1,2,3,0; each request is issued exactly once.
4. Backpressure: ch_req_ready low for 5 cycles, then rsp_ready[1] low for 4 cycles -> channel fields and rsp fields held stable; no new grant until the rsp handshake.
5. Reset in WAIT: assert rst_n low, then drive ch_rsp_valid after release -> all outputs 0; no rsp_valid; the next request completes normally.
6. Timeout (feature on, TIMEOUT_CYCLES=16): no channel response -> rsp_ret=0xFFFFFFFF 16 cycles after WAIT entry. Feature off: rsp_valid stays 0 for 2000 cycles.
